// File: rtl/dvi_fifo_writer.sv
// dvi_fifo_writer
//   Takes a DVI pixel stream (de/vsync/rgb) on clk_25, tracks the pixel
//   position, and pushes in-range pixels into a FIFO as packed words
//   {x[9:0], y[9:0], r, g, b}. If the FIFO is full when a pixel must be
//   written, the rest of the frame is discarded and counted until the next
//   frame start.
//
// Ports
//   clk_25       in   pixel clock (rising edge)
//   rst          in   asynchronous active-high reset
//   dvi_de       in   data enable, one pixel per high cycle
//   dvi_vsync    in   vertical sync, rising edge = frame start
//   dvi_r/g/b    in   8-bit colour components
//   wrclk        out  FIFO write clock (clk_25 passed through)
//   wrreq        out  FIFO write request (registered)
//   data         out  FIFO write word (registered, holds when wrreq low)
//   wrfull       in   FIFO full flag, synchronous to clk_25
//   frame_start  out  one-cycle pulse per detected vsync rising edge
//   overflow     out  sticky: a pixel was dropped since reset
//   drop_cnt     out  saturating count of dropped in-range pixels
module dvi_fifo_writer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk_25,
  input  logic        rst,
  input  logic        dvi_de,
  input  logic        dvi_vsync,
  input  logic [7:0]  dvi_r,
  input  logic [7:0]  dvi_g,
  input  logic [7:0]  dvi_b,
  output logic        wrclk,
  output logic        wrreq,
  output logic [43:0] data,
  input  logic        wrfull,
  output logic        frame_start,
  output logic        overflow,
  output logic [15:0] drop_cnt
);

  typedef enum logic [1:0] {S_SYNC, S_ACTIVE, S_DROP} state_t;

  // Limits widened by one bit so a limit of 1024 still compares correctly.
  localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM = 11'(V_ACTIVE);

  state_t      state;
  logic        de_p1, vsync_p1, de_p1_d, vsync_p1_d;
  logic [7:0]  r_p1, g_p1, b_p1;
  logic [9:0]  x, y;

  logic vs_edge, de_fall, pix, in_range, wr_ok, drop;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign wrclk = clk_25;

  always_comb begin
    vs_edge  = vsync_p1 & ~vsync_p1_d;
    de_fall  = de_p1_d & ~de_p1;
    // A pixel coinciding with the vsync edge belongs to no frame: ignore it.
    pix      = de_p1 & ~vs_edge;
    in_range = pix && ({1'b0, x} < H_LIM) && ({1'b0, y} < V_LIM);
    wr_ok    = (state == S_ACTIVE) && in_range && !wrfull;
    drop     = in_range && (((state == S_ACTIVE) && wrfull) || (state == S_DROP));
  end

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      state       <= S_SYNC;
      de_p1       <= 1'b0;
      vsync_p1    <= 1'b0;
      de_p1_d     <= 1'b0;
      vsync_p1_d  <= 1'b0;
      r_p1        <= '0;
      g_p1        <= '0;
      b_p1        <= '0;
      x           <= '0;
      y           <= '0;
      wrreq       <= 1'b0;
      data        <= '0;
      frame_start <= 1'b0;
      overflow    <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      // Stage 1: register the raw DVI inputs and keep their previous values
      de_p1      <= dvi_de;
      vsync_p1   <= dvi_vsync;
      r_p1       <= dvi_r;
      g_p1       <= dvi_g;
      b_p1       <= dvi_b;
      de_p1_d    <= de_p1;
      vsync_p1_d <= vsync_p1;

      // Stage 2: decisions on stage-1 values drive the registered outputs
      frame_start <= vs_edge;
      wrreq       <= wr_ok;
      if (wr_ok) data <= {x, y, r_p1, g_p1, b_p1};
      if (drop) begin
        overflow <= 1'b1;
        drop_cnt <= sat_inc16(drop_cnt);
      end

      if (vs_edge) begin
        x <= '0;
        y <= '0;
      end else if (pix) begin
        x <= sat_inc10(x);
      end else if (de_fall) begin
        x <= '0;
        y <= sat_inc10(y);
      end

      case (state)
        S_SYNC:   if (vs_edge) state <= S_ACTIVE;
        S_ACTIVE: if (drop)    state <= S_DROP;
        S_DROP:   if (vs_edge) state <= S_ACTIVE;
        default:  state <= S_SYNC;
      endcase
    end
  end

endmodule
